piso_serializer: RTL and testbench

- Downstream stage of the 4-bit parallel-in/parallel-out register.
- Accepts one parallel word per handshake and shifts it out MSB-first on a single serial line.
- Each bit is held for one slow-tick period, generated by an internal power-of-two clock divider.
- Drives LEDs or a serial pin at human-visible rates on hardware; a small DIV_BITS gives fast simulation.

---
 rtl/piso_serializer.sv | 125 ++++++++++++
 tb/tb_piso_serializer.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out shifter: one word per handshake, MSB first, each bit held 2^DIV_BITS clocks.
// Optional trailing even-parity bit when PISO_PARITY_EN is defined.
module piso_serializer #(
  parameter int WIDTH    = 4,
  parameter int DIV_BITS = 26
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);

`ifdef PISO_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
  typedef enum logic {IDLE, SHIFT} state_t;
`endif

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    shift_q, shift_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [DIV_BITS-1:0] div_q, div_d;
  logic                done_q, done_d;
  logic                tick;
`ifdef PISO_PARITY_EN
  logic                parity_q, parity_d;
`endif

  assign tick = &div_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      div_q   <= '0;
      done_q  <= 1'b0;
`ifdef PISO_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      done_q  <= done_d;
`ifdef PISO_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    done_d  = 1'b0;
`ifdef PISO_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      IDLE: begin
        // Divider held at zero so the first bit gets a full period.
        div_d = '0;
        if (din_valid) begin
          shift_d = din;
          cnt_d   = '0;
          state_d = SHIFT;
`ifdef PISO_PARITY_EN
          parity_d = ^din;
`endif
        end
      end
      SHIFT: begin
        div_d = div_q + 1'b1;
        if (tick) begin
          if (cnt_q != CW'(WIDTH - 1)) begin
            shift_d = {shift_q[WIDTH-2:0], 1'b0};
            cnt_d   = cnt_q + 1'b1;
          end else begin
`ifdef PISO_PARITY_EN
            state_d = PARITY;
`else
            state_d = IDLE;
            done_d  = 1'b1;
`endif
          end
        end
      end
`ifdef PISO_PARITY_EN
      PARITY: begin
        div_d = div_q + 1'b1;
        if (tick) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sout = 1'b1;
    case (state_q)
      SHIFT:   sout = shift_q[WIDTH-1];
`ifdef PISO_PARITY_EN
      PARITY:  sout = parity_q;
`endif
      default: sout = 1'b1;
    endcase
  end

  assign din_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign done      = done_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer at WIDTH=4, DIV_BITS=2 (bit period 4 clocks).
// Define PISO_PARITY_EN for both bench and RTL to cover the parity bit.
module tb_piso_serializer;

  localparam int T = 4;
`ifdef PISO_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int L = (4 + P) * T;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] din;
  logic       din_valid;
  logic       din_ready;
  logic       sout;
  logic       busy;
  logic       done;

  int compared   = 0;
  int mismatched = 0;

  piso_serializer #(.WIDTH(4), .DIV_BITS(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .sout      (sout),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic [3:0] w, input logic v);
    din       = w;
    din_valid = v;
  endtask

  task automatic checkOutput(input string tag, input logic obs, input logic exp_v);
    compared++;
    assert (obs === exp_v) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp_v);
    end
  endtask

  // Expected serial bit in cycle c (1-based from the accept edge) for word w.
  function automatic logic expBit(input logic [3:0] w, input int c);
    if (c <= 4 * T) return w[3 - (c - 1) / T];
    return ^w;
  endfunction

  task automatic checkIdle(input string tag);
    checkOutput({tag, ".sout"}, sout, 1'b1);
    checkOutput({tag, ".busy"}, busy, 1'b0);
    checkOutput({tag, ".done"}, done, 1'b0);
    checkOutput({tag, ".ready"}, din_ready, 1'b1);
  endtask

  task automatic checkStream(input string tag, input logic [3:0] w, input int c);
    string t;
    t = $sformatf("%s.c%0d", tag, c);
    if (c <= L) begin
      checkOutput({t, ".sout"}, sout, expBit(w, c));
      checkOutput({t, ".busy"}, busy, 1'b1);
      checkOutput({t, ".done"}, done, 1'b0);
      checkOutput({t, ".ready"}, din_ready, 1'b0);
    end else begin
      checkOutput({t, ".sout"}, sout, 1'b1);
      checkOutput({t, ".busy"}, busy, 1'b0);
      checkOutput({t, ".done"}, done, 1'b1);
      checkOutput({t, ".ready"}, din_ready, 1'b1);
    end
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(4'b0000, 1'b0);
    #2;
    checkIdle("reset_async");
    #20;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkIdle("post_reset");

    // Single word with a rejected offer in cycle 6.
    applyStimulus(4'b1011, 1'b1);
    for (int c = 1; c <= L + 1; c++) begin
      @(negedge clk);
      if (c == 1) applyStimulus(4'b1011, 1'b0);
      if (c == 6) begin
        applyStimulus(4'b0000, 1'b1);
        checkOutput("reject.ready", din_ready, 1'b0);
      end
      if (c == 7) applyStimulus(4'b0000, 1'b0);
      checkStream("single", 4'b1011, c);
    end
    @(negedge clk);
    checkIdle("single_after");

    // Back-to-back: valid held high, second word accepted on the done cycle.
    applyStimulus(4'b1011, 1'b1);
    for (int c = 1; c <= 2 * L + 2; c++) begin
      @(negedge clk);
      if (c == 1) applyStimulus(4'b0110, 1'b1);
      if (c == L + 2) applyStimulus(4'b0110, 1'b0);
      if (c <= L + 1) checkStream("b2b_first", 4'b1011, c);
      else checkStream("b2b_second", 4'b0110, c - L - 1);
    end
    @(negedge clk);
    checkIdle("b2b_after");

    // Reset mid-word loses the word and produces no done.
    applyStimulus(4'b1011, 1'b1);
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      if (c == 1) applyStimulus(4'b1011, 1'b0);
      if (c < 7) checkStream("pre_reset", 4'b1011, c);
    end
    reset = 1'b1;
    #1;
    checkIdle("mid_reset");
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkIdle($sformatf("held_reset%0d", c));
    end
    reset = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checkIdle($sformatf("released%0d", c));
    end

    applyStimulus(4'b1000, 1'b1);
    for (int c = 1; c <= L + 1; c++) begin
      @(negedge clk);
      if (c == 1) applyStimulus(4'b1000, 1'b0);
      checkStream("after_reset", 4'b1000, c);
    end
    @(negedge clk);
    checkIdle("final_idle");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
